y_compare_misr: RTL and testbench
=================================

Y_COMPARE_MISR -- requirements
Module: y_compare_misr

Interface
REQ-001 SHALL have parameter WIDTH, default 81, the width of the compared output vector y.
REQ-002 SHALL have parameter SIG_POLY, default 32'h04C11DB7, the MISR feedback polynomial.
REQ-003 SHALL have parameter SIG_SEED, default 32'hFFFFFFFF, the MISR start value.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  request to begin a run, sampled in IDLE or DONE.
REQ-007 SHALL have port num_cycles  input  16  number of samples per run, latched at start.
REQ-008 SHALL have port valid_in  input  1  y_ref/y_dut sample qualifier.
REQ-009 SHALL have port y_ref  input  WIDTH  golden-model output.
REQ-010 SHALL have port y_dut  input  WIDTH  synthesized-netlist output.
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port done  output  1  high in DONE.
REQ-013 SHALL have port pass  output  1  high in DONE when mismatch_count==0, else 0.
REQ-014 SHALL have port mismatch_count  output  16  mismatching samples this run, saturating.
REQ-015 SHALL have port first_mm_valid  output  1  a first mismatch has been captured.
REQ-016 SHALL have port first_mm_index  output  16  sample index (0-based) of the first mismatch.
REQ-017 SHALL have port first_mm_diff  output  WIDTH  y_ref XOR y_dut at the first mismatch.
REQ-018 SHALL have port signature  output  32  MISR over y_dut samples.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE.
REQ-020 IDLE or DONE with start=1 SHALL load: latched N=num_cycles; sample_idx=0; mismatch_count=0; first_mm_valid=0; first_mm_index=0; first_mm_diff=0; signature=SIG_SEED. Next state: RUN if N!=0, else DONE.
REQ-021 start in RUN SHALL be ignored.
REQ-022 In RUN, each cycle with valid_in=1 SHALL be one sample; cycles with valid_in=0 SHALL change nothing.
REQ-023 Each sample SHALL update signature:
- sig_next = {sig[30:0],1'b0} ^ (sig[31] ? SIG_POLY : 0) ^ fold(y_dut).
- fold = XOR of y_dut split into 32-bit chunks from bit 0, top chunk zero-padded.
REQ-024 A sample with y_ref!=y_dut SHALL increment mismatch_count, holding at 16'hFFFF.
REQ-025 The first mismatching sample of a run SHALL set first_mm_valid=1, first_mm_index=sample_idx, and first_mm_diff=y_ref^y_dut.
- Later mismatches SHALL NOT alter these values.
REQ-026 The sample with sample_idx==N-1 SHALL be fully accounted; then the state goes to DONE in the next cycle.
- sample_idx SHALL increment per sample otherwise.
REQ-027 In DONE all result outputs SHALL hold until the next accepted start.
REQ-028 Outputs SHALL be registered; the effect of a sample SHALL be visible one cycle after the sampling edge.
REQ-029 pass SHALL be 0 outside DONE.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE and set the following regardless of clk:
- busy=0, done=0, pass=0
- mismatch_count=0, first_mm_valid=0, first_mm_index=0, first_mm_diff=0
- signature=SIG_SEED
REQ-031 Reset asserted mid-RUN SHALL abandon the run with no partial result retained.
- After release, the block SHALL wait in IDLE for start.

Verification
REQ-032 start, N=1, one sample y_ref=y_dut=0 -> done=1, pass=1, mismatch_count=0, signature=32'hFB3EE249.
REQ-033 start, N=4, samples equal except idx 2 where y_dut=y_ref^81'h1 -> mismatch_count=1, first_mm_index=2, first_mm_diff=81'h1, pass=0.
REQ-034 start with N=0 -> DONE next cycle, pass=1, signature=32'hFFFFFFFF, busy never high.
REQ-035 N=3 with valid_in low on alternating cycles -> exactly 3 samples counted; done only after the third valid sample.
REQ-036 rst_n pulsed low mid-RUN after 2 mismatches -> all outputs at reset values; new start with N=1 and matching sample -> pass=1.
REQ-037 N=16'hFFFF, start, then 70000 cycles with valid_in=1 and all mismatching -> count saturates at 16'hFFFF; start during RUN has no effect; first_mm_index=0.

Source files
------------

// File: rtl/y_compare_misr.sv
// y_compare_misr
// Compares a golden-model output vector (y_ref) against a netlist output
// vector (y_dut) over a run of num_cycles qualified samples, and compresses
// y_dut into a 32-bit MISR signature.
//
// Parameters
//   WIDTH     width of y_ref / y_dut
//   SIG_POLY  MISR feedback polynomial
//   SIG_SEED  MISR start value
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            begin a run (honoured in IDLE or DONE only)
//   num_cycles       samples per run, latched at start
//   valid_in         qualifies y_ref / y_dut as one sample
//   y_ref, y_dut     compared vectors
//   busy / done      run in progress / run finished
//   pass             DONE with zero mismatches
//   mismatch_count   saturating count of mismatching samples
//   first_mm_*       index and XOR difference of the first mismatch
//   signature        MISR over y_dut
//   dbg_state        current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: there is no backpressure. A sample is accepted on every rising
// edge in RUN where valid_in=1; valid_in=0 cycles leave all state untouched.
module y_compare_misr #(
  parameter int          WIDTH    = 81,
  parameter logic [31:0] SIG_POLY = 32'h04C11DB7,
  parameter logic [31:0] SIG_SEED = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_cycles,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] y_ref,
  input  logic [WIDTH-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mismatch_count,
  output logic             first_mm_valid,
  output logic [15:0]      first_mm_index,
  output logic [WIDTH-1:0] first_mm_diff,
  output logic [31:0]      signature,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NCHUNK = (WIDTH + 31) / 32;

  state_t      state;
  logic [15:0] n_lat;
  logic [15:0] sample_idx;

  // XOR of y split into 32-bit chunks from bit 0, top chunk zero-padded.
  function automatic logic [31:0] fold(input logic [WIDTH-1:0] v);
    logic [NCHUNK*32-1:0] padded;
    logic [31:0]          acc;
    padded            = '0;
    padded[WIDTH-1:0] = v;
    acc               = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      acc = acc ^ padded[i*32 +: 32];
    end
    return acc;
  endfunction

  logic [31:0]      sig_next;
  logic             mm;
  logic [WIDTH-1:0] diff;
  logic [15:0]      count_next;
  logic             last_sample;

  always_comb begin
    sig_next    = {signature[30:0], 1'b0} ^ (signature[31] ? SIG_POLY : 32'h0) ^ fold(y_dut);
    diff        = y_ref ^ y_dut;
    mm          = (diff != '0);
    count_next  = mismatch_count;
    if (mm && (mismatch_count != 16'hFFFF)) begin
      count_next = mismatch_count + 16'd1;
    end
    // n_lat is never 0 while in RUN, so n_lat-1 cannot wrap here.
    last_sample = (sample_idx == (n_lat - 16'd1));
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      n_lat          <= '0;
      sample_idx     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_mm_valid <= 1'b0;
      first_mm_index <= '0;
      first_mm_diff  <= '0;
      signature      <= SIG_SEED;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_lat          <= num_cycles;
            sample_idx     <= '0;
            mismatch_count <= '0;
            first_mm_valid <= 1'b0;
            first_mm_index <= '0;
            first_mm_diff  <= '0;
            signature      <= SIG_SEED;
            if (num_cycles != 16'd0) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end else begin
              // Empty run: nothing compared, so it trivially passes.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (valid_in) begin
            signature      <= sig_next;
            mismatch_count <= count_next;
            if (mm && !first_mm_valid) begin
              first_mm_valid <= 1'b1;
              first_mm_index <= sample_idx;
              first_mm_diff  <= diff;
            end
            if (last_sample) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Include the final sample's own comparison result.
              pass  <= (count_next == 16'd0);
            end else begin
              sample_idx <= sample_idx + 16'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_compare_misr.sv
// Directed testbench for y_compare_misr.
module tb_y_compare_misr;

  localparam int          WIDTH = 81;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [15:0]      num_cycles;
  logic             valid_in;
  logic [WIDTH-1:0] y_ref;
  logic [WIDTH-1:0] y_dut;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      mismatch_count;
  logic             first_mm_valid;
  logic [15:0]      first_mm_index;
  logic [WIDTH-1:0] first_mm_diff;
  logic [31:0]      signature;
  logic [1:0]       dbg_state;

  int checks;
  int failures;

  y_compare_misr #(.WIDTH(WIDTH), .SIG_POLY(POLY), .SIG_SEED(SEED)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_cycles     (num_cycles),
    .valid_in       (valid_in),
    .y_ref          (y_ref),
    .y_dut          (y_dut),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .first_mm_valid (first_mm_valid),
    .first_mm_index (first_mm_index),
    .first_mm_diff  (first_mm_diff),
    .signature      (signature),
    .dbg_state      (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MISR step written from the polynomial description.
  function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [WIDTH-1:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ {15'h0, y[80:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] r2 [4];
  logic [WIDTH-1:0] r4 [3];
  logic [31:0]      ms;
  int               nvalid;
  int               vidx;

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_cycles = '0;
    valid_in   = 1'b0;
    y_ref      = '0;
    y_dut      = '0;
    r2[0] = 81'h0_0000_0000_0000_0000_0000;
    r2[1] = 81'h1_DEAD_BEEF_CAFE_F00D_1234;
    r2[2] = 81'h0_1234_5678_9ABC_DEF0_0F0F;
    r2[3] = 81'h1_FFFF_FFFF_FFFF_FFFF_FFFF;
    r4[0] = 81'h0_0000_0000_0000_0000_0001;
    r4[1] = 81'h1_8000_0000_0000_0000_0000;
    r4[2] = 81'h0_5555_AAAA_5555_AAAA_5555;

    // ---- reset values
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_count", mismatch_count, 0);
    check("rst_sig", signature, SEED);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_wait", dbg_state, 0);

    // ---- N=1, one zero sample
    start = 1'b1; num_cycles = 16'd1;
    tick();
    start = 1'b0;
    check("n1_busy", busy, 1);
    valid_in = 1'b1; y_ref = '0; y_dut = '0;
    tick();
    valid_in = 1'b0;
    check("n1_done", done, 1);
    check("n1_pass", pass, 1);
    check("n1_busy_low", busy, 0);
    check("n1_count", mismatch_count, 0);
    check("n1_sig", signature, 32'hFB3EE249);
    tick();
    check("n1_hold_sig", signature, 32'hFB3EE249);

    // ---- N=4, mismatch at idx 2
    start = 1'b1; num_cycles = 16'd4;
    tick();
    start = 1'b0;
    check("n4_restart_count", mismatch_count, 0);
    check("n4_restart_done", done, 0);
    ms = SEED;
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1;
      y_ref    = r2[k];
      y_dut    = (k == 2) ? (r2[k] ^ 81'h1) : r2[k];
      ms       = ref_misr(ms, y_dut);
      tick();
      if (k == 2) begin
        check("n4_count_at2", mismatch_count, 1);
        check("n4_busy_at2", busy, 1);
      end
    end
    valid_in = 1'b0;
    check("n4_done", done, 1);
    check("n4_count", mismatch_count, 1);
    check("n4_fvalid", first_mm_valid, 1);
    check("n4_findex", first_mm_index, 2);
    check("n4_fdiff", first_mm_diff, 81'h1);
    check("n4_pass", pass, 0);
    check("n4_sig", signature, ms);

    // ---- N=0
    start = 1'b1; num_cycles = 16'd0;
    tick();
    start = 1'b0;
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);
    check("n0_pass", pass, 1);
    check("n0_sig", signature, SEED);
    check("n0_fvalid", first_mm_valid, 0);

    // ---- N=3, valid on alternating cycles
    start = 1'b1; num_cycles = 16'd3;
    tick();
    start = 1'b0;
    ms = SEED; nvalid = 0; vidx = 0;
    for (int i = 0; i < 6; i++) begin
      valid_in = i[0];
      y_ref    = r4[vidx];
      y_dut    = r4[vidx];
      if (valid_in) begin
        ms = ref_misr(ms, y_dut);
        nvalid++;
      end
      tick();
      if (valid_in && vidx < 2) vidx++;
      check($sformatf("alt_done_%0d", i), done, (nvalid == 3));
    end
    valid_in = 1'b0;
    check("alt_pass", pass, 1);
    check("alt_sig", signature, ms);

    // ---- reset mid-run after 2 mismatches
    start = 1'b1; num_cycles = 16'd5;
    tick();
    start = 1'b0;
    valid_in = 1'b1; y_ref = 81'h3; y_dut = 81'h0;
    tick();
    tick();
    valid_in = 1'b0;
    check("mid_count2", mismatch_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", mismatch_count, 0);
    check("mid_rst_fvalid", first_mm_valid, 0);
    check("mid_rst_findex", first_mm_index, 0);
    check("mid_rst_fdiff", first_mm_diff, 0);
    check("mid_rst_sig", signature, SEED);
    check("mid_rst_pass", pass, 0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("mid_idle_state", dbg_state, 0);
    check("mid_idle_done", done, 0);
    start = 1'b1; num_cycles = 16'd1;
    tick();
    start = 1'b0;
    valid_in = 1'b1; y_ref = r2[1]; y_dut = r2[1];
    tick();
    valid_in = 1'b0;
    check("mid_new_done", done, 1);
    check("mid_new_pass", pass, 1);
    check("mid_new_sig", signature, ref_misr(SEED, r2[1]));

    // ---- saturation run with ignored start
    start = 1'b1; num_cycles = 16'hFFFF;
    tick();
    start = 1'b0;
    valid_in = 1'b1; y_ref = 81'h0; y_dut = 81'h1;
    for (int i = 0; i < 70000; i++) begin
      if (i == 100) begin
        start = 1'b1; num_cycles = 16'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      if (i == 101) check("sat_busy_after_start", busy, 1);
      if (i == 200) check("sat_count_201", mismatch_count, 201);
      if (i == 65533) check("sat_not_done_early", done, 0);
    end
    valid_in = 1'b0;
    check("sat_count", mismatch_count, 16'hFFFF);
    check("sat_done", done, 1);
    check("sat_pass", pass, 0);
    check("sat_findex", first_mm_index, 0);
    check("sat_fdiff", first_mm_diff, 81'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
